// File: rtl/pixel_write_arbiter.sv
// Round-robin arbiter sharing one frame-buffer write port between NUM_CORES pixel streams.
// Define ARB_STATS_EN to add saturating stall/drop counters as extra output ports.
module pixel_write_arbiter #(
  parameter int NUM_CORES      = 4,
  parameter int H_BITS         = 9,
  parameter int V_BITS         = 8,
  parameter int ADDR_BITS      = 17,
  parameter int COLOR_BITS     = 4,
  parameter int DISPLAY_WIDTH  = 320,
  parameter int DISPLAY_HEIGHT = 240
) (
  input  logic                             clk_in,
  input  logic                             rst_in,
  input  logic [NUM_CORES-1:0]             core_valid_in,
  output logic [NUM_CORES-1:0]             core_ready_out,
  input  logic [NUM_CORES*H_BITS-1:0]      core_hcount_in,
  input  logic [NUM_CORES*V_BITS-1:0]      core_vcount_in,
  input  logic [NUM_CORES*COLOR_BITS-1:0]  core_color_in,
  input  logic [NUM_CORES-1:0]             core_frame_done_in,
  output logic                             write_enable_out,
  output logic [ADDR_BITS-1:0]             write_addr_out,
  output logic [COLOR_BITS-1:0]            write_data_out,
  output logic                             swap_buffers_out
`ifdef ARB_STATS_EN
  ,
  output logic [31:0]                      stall_count_out,
  output logic [31:0]                      drop_count_out
`endif
);

  localparam int          IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam logic [31:0] DW_U  = 32'(DISPLAY_WIDTH);
  localparam logic [31:0] DH_U  = 32'(DISPLAY_HEIGHT);

  logic [NUM_CORES-1:0]  full_q, full_d;
  logic [NUM_CORES-1:0]  done_q, done_d;
  logic [NUM_CORES-1:0]  grant_vec, accept;
  logic [H_BITS-1:0]     hcount_q [NUM_CORES];
  logic [V_BITS-1:0]     vcount_q [NUM_CORES];
  logic [COLOR_BITS-1:0] color_q  [NUM_CORES];
  logic [IDX_W-1:0]      rr_q, grant_idx, cand;
  logic                  grant_valid;

  logic                  we_q, we_d;
  logic [ADDR_BITS-1:0]  addr_q, addr_d;
  logic [COLOR_BITS-1:0] data_q, data_d;

  logic [H_BITS-1:0]     sel_h;
  logic [V_BITS-1:0]     sel_v;
  logic [COLOR_BITS-1:0] sel_c;
  logic                  in_range;
  logic [31:0]           lin_addr;
  logic                  swap_now;

  // Search begins one past the last winner so every full entry is served within NUM_CORES cycles.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = rr_q;
    grant_vec   = '0;
    cand        = '0;
    for (int unsigned k = 1; k <= NUM_CORES; k++) begin
      cand = IDX_W'((32'(rr_q) + k) % NUM_CORES);
      if (!grant_valid && full_q[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
    if (grant_valid) grant_vec[grant_idx] = 1'b1;
  end

  assign core_ready_out = ~full_q | grant_vec;
  assign accept         = core_valid_in & core_ready_out;

  always_comb begin
    sel_h    = hcount_q[grant_idx];
    sel_v    = vcount_q[grant_idx];
    sel_c    = color_q[grant_idx];
    in_range = (32'(sel_h) < DW_U) && (32'(sel_v) < DH_U);
    lin_addr = 32'(sel_v) * DW_U + 32'(sel_h);
    we_d     = grant_valid & in_range;
    addr_d   = we_d ? ADDR_BITS'(lin_addr) : addr_q;
    data_d   = we_d ? sel_c : data_q;
    full_d   = (full_q & ~grant_vec) | accept;
  end

  // Swap depends only on registered state, so the last write always precedes it by a cycle.
  assign swap_now = (&done_q) & ~(|full_q) & ~grant_valid & ~we_q;

  always_comb begin
    done_d = (swap_now ? '0 : done_q) | core_frame_done_in;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      full_q <= '0;
      done_q <= '0;
      rr_q   <= '0;
      we_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      done_q <= done_d;
      if (grant_valid) rr_q <= grant_idx;
      we_q   <= we_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end

  always_ff @(posedge clk_in) begin
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      if (accept[i]) begin
        hcount_q[i] <= core_hcount_in[i*H_BITS +: H_BITS];
        vcount_q[i] <= core_vcount_in[i*V_BITS +: V_BITS];
        color_q[i]  <= core_color_in[i*COLOR_BITS +: COLOR_BITS];
      end
    end
  end

  assign write_enable_out = we_q;
  assign write_addr_out   = addr_q;
  assign write_data_out   = data_q;
  assign swap_buffers_out = swap_now;

`ifdef ARB_STATS_EN
  logic [31:0] stall_q, stall_d;
  logic [31:0] drop_q, drop_d;
  logic        stall_ev, drop_ev;

  always_comb begin
    stall_ev = |(core_valid_in & ~core_ready_out);
    drop_ev  = grant_valid & ~in_range;
    stall_d  = (stall_ev && stall_q != '1) ? stall_q + 32'd1 : stall_q;
    drop_d   = (drop_ev && drop_q != '1) ? drop_q + 32'd1 : drop_q;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      stall_q <= '0;
      drop_q  <= '0;
    end else begin
      stall_q <= stall_d;
      drop_q  <= drop_d;
    end
  end

  assign stall_count_out = stall_q;
  assign drop_count_out  = drop_q;
`endif

endmodule

// File: tb/tb_pixel_write_arbiter.sv
// Scoreboard bench for pixel_write_arbiter: expected writes queued at stimulus time, checked on output.
module tb_pixel_write_arbiter;

  localparam int NC = 4;
  localparam int HB = 9;
  localparam int VB = 8;
  localparam int AB = 17;
  localparam int CB = 4;
  localparam int DW = 320;
  localparam int DH = 240;

  typedef struct {
    logic [AB-1:0] a;
    logic [CB-1:0] d;
  } wr_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [NC-1:0]     valid, ready, fdone;
  logic [NC*HB-1:0]  hc;
  logic [NC*VB-1:0]  vc;
  logic [NC*CB-1:0]  cc;
  logic              we, swap;
  logic [AB-1:0]     addr;
  logic [CB-1:0]     data;
`ifdef ARB_STATS_EN
  logic [31:0]       stall_cnt, drop_cnt;
`endif

  always #5 clk = ~clk;

  pixel_write_arbiter #(
    .NUM_CORES(NC), .H_BITS(HB), .V_BITS(VB), .ADDR_BITS(AB),
    .COLOR_BITS(CB), .DISPLAY_WIDTH(DW), .DISPLAY_HEIGHT(DH)
  ) dut (
    .clk_in(clk), .rst_in(rst),
    .core_valid_in(valid), .core_ready_out(ready),
    .core_hcount_in(hc), .core_vcount_in(vc), .core_color_in(cc),
    .core_frame_done_in(fdone),
    .write_enable_out(we), .write_addr_out(addr), .write_data_out(data),
    .swap_buffers_out(swap)
`ifdef ARB_STATS_EN
    , .stall_count_out(stall_cnt), .drop_count_out(drop_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  wr_t exp_q[$];
  int  wr_cyc_q[$];
  int  swap_cyc_q[$];
  wr_t mon_e;

  logic [HB-1:0] ph [NC][8];
  logic [VB-1:0] pv [NC][8];
  logic [CB-1:0] pc [NC][8];
  int npix [NC];
  int first_hs;
  int notready0;
  int ready_cnt [NC];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (we === 1'b1) begin
      wr_cyc_q.push_back(cyc);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write got addr %0d data %0d want no write", addr, data);
      end else begin
        mon_e = exp_q.pop_front();
        if (addr !== mon_e.a || data !== mon_e.d) begin
          errors++;
          $display("FAIL write got addr %0d data %0d want addr %0d data %0d",
                   addr, data, mon_e.a, mon_e.d);
        end
      end
    end
    if (swap === 1'b1) swap_cyc_q.push_back(cyc);
  end

  function automatic void push_exp(input int h, input int v, input int c);
    wr_t e;
    e.a = AB'(v * DW + h);
    e.d = CB'(c);
    exp_q.push_back(e);
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1; valid = '0; fdone = '0;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    wr_cyc_q.delete();
    swap_cyc_q.delete();
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain got %0d pending writes want 0", name, exp_q.size());
    end
  endtask

  task automatic run_stream(input int win_lo, input int win_hi);
    int sent [NC];
    logic [NC-1:0] acc;
    int t;
    bit done_all;
    acc = '0; t = 0; first_hs = -1; notready0 = 0; done_all = 1'b0;
    for (int i = 0; i < NC; i++) begin
      sent[i] = 0;
      ready_cnt[i] = 0;
    end
    while (1) begin
      @(negedge clk);
      for (int i = 0; i < NC; i++) if (acc[i]) sent[i]++;
      done_all = 1'b1;
      for (int i = 0; i < NC; i++) if (sent[i] < npix[i]) done_all = 1'b0;
      if (done_all || t >= 200) break;
      for (int i = 0; i < NC; i++) begin
        valid[i] = (sent[i] < npix[i]);
        if (valid[i]) begin
          hc[i*HB +: HB] = ph[i][sent[i]];
          vc[i*VB +: VB] = pv[i][sent[i]];
          cc[i*CB +: CB] = pc[i][sent[i]];
        end
      end
      acc = valid & ready;
      if (acc != '0 && first_hs < 0) first_hs = cyc;
      for (int i = 0; i < NC; i++)
        if (t >= win_lo && t <= win_hi && ready[i]) ready_cnt[i]++;
      if (valid[0] && !ready[0]) notready0++;
      t++;
    end
    valid = '0;
    checks++;
    if (!done_all) begin
      errors++;
      $display("FAIL stream_timeout got %0d cycles want all pixels accepted", t);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (we !== 1'b0)   begin errors++; $display("FAIL reset_we got %b want 0", we); end
    checks++; if (addr !== '0)   begin errors++; $display("FAIL reset_addr got %0d want 0", addr); end
    checks++; if (data !== '0)   begin errors++; $display("FAIL reset_data got %0d want 0", data); end
    checks++; if (swap !== 1'b0) begin errors++; $display("FAIL reset_swap got %b want 0", swap); end
    checks++; if (ready !== '1)  begin errors++; $display("FAIL reset_ready got %b want 1111", ready); end
  endtask

  task automatic test_single_core();
    apply_reset();
    for (int i = 0; i < NC; i++) npix[i] = 0;
    npix[0] = 4;
    for (int k = 0; k < 4; k++) begin
      ph[0][k] = HB'(k); pv[0][k] = '0; pc[0][k] = CB'(k + 1);
      push_exp(k, 0, k + 1);
    end
    run_stream(0, -1);
    wait_drain("single");
    checks++;
    if (notready0 != 0) begin errors++; $display("FAIL single_ready got %0d stalls want 0", notready0); end
    checks++;
    if (wr_cyc_q.size() != 4) begin
      errors++; $display("FAIL single_count got %0d writes want 4", wr_cyc_q.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (wr_cyc_q[k] != first_hs + 2 + k) begin
          errors++;
          $display("FAIL single_latency write %0d got cycle %0d want %0d", k, wr_cyc_q[k], first_hs + 2 + k);
        end
      end
    end
  endtask

  task automatic test_round_robin();
    int c;
    apply_reset();
    for (int i = 0; i < NC; i++) begin
      npix[i] = 5;
      for (int k = 0; k < 5; k++) begin
        ph[i][k] = HB'(10 * i + k); pv[i][k] = VB'(i + 1); pc[i][k] = CB'(i * 5 + k + 1);
      end
    end
    for (int r = 0; r < 5; r++)
      for (int j = 1; j <= NC; j++) begin
        c = j % NC;
        push_exp(10 * c + r, c + 1, (c * 5 + r + 1) % 16);
      end
    run_stream(1, 16);
    wait_drain("rr");
    for (int i = 0; i < NC; i++) begin
      checks++;
      if (ready_cnt[i] != 4) begin
        errors++; $display("FAIL rr_ready core %0d got %0d ready cycles want 4", i, ready_cnt[i]);
      end
    end
    checks++;
    if (wr_cyc_q.size() != 20) begin
      errors++; $display("FAIL rr_count got %0d writes want 20", wr_cyc_q.size());
    end else begin
      checks++;
      if (wr_cyc_q[0] != first_hs + 2) begin
        errors++; $display("FAIL rr_first got cycle %0d want %0d", wr_cyc_q[0], first_hs + 2);
      end
      checks++;
      if (wr_cyc_q[19] != wr_cyc_q[0] + 19) begin
        errors++; $display("FAIL rr_back_to_back got span %0d want 19", wr_cyc_q[19] - wr_cyc_q[0]);
      end
    end
  endtask

  task automatic test_out_of_range();
    apply_reset();
    for (int i = 0; i < NC; i++) npix[i] = 0;
    npix[0] = 3;
    ph[0][0] = 9'd5;   pv[0][0] = 8'd2;   pc[0][0] = 4'd7;
    ph[0][1] = 9'd319; pv[0][1] = 8'd239; pc[0][1] = 4'd8;
    ph[0][2] = 9'd320; pv[0][2] = 8'd0;   pc[0][2] = 4'd9;
    push_exp(5, 2, 7);
    push_exp(319, 239, 8);
    run_stream(0, -1);
    wait_drain("oob");
    checks++;
    if (wr_cyc_q.size() != 2) begin
      errors++; $display("FAIL oob_count got %0d writes want 2", wr_cyc_q.size());
    end
    checks++;
    if (we !== 1'b0 || addr !== 17'd76799 || data !== 4'd8) begin
      errors++; $display("FAIL oob_hold got we %b addr %0d data %0d want 0 76799 8", we, addr, data);
    end
`ifdef ARB_STATS_EN
    checks++;
    if (drop_cnt !== 32'd1) begin errors++; $display("FAIL oob_drop got %0d want 1", drop_cnt); end
`endif
  endtask

  task automatic test_frame_done();
    int base;
    apply_reset();
    base = cyc;
    for (int t = 0; t <= 50; t++) begin
      if (t > 0) @(negedge clk);
      fdone = '0; valid = '0;
      case (t)
        10: fdone[0] = 1'b1;
        12: fdone[2:1] = 2'b11;
        15: fdone[0] = 1'b1;
        19: begin
          valid[3] = 1'b1;
          hc[3*HB +: HB] = 9'd100; vc[3*VB +: VB] = 8'd50; cc[3*CB +: CB] = 4'd9;
          push_exp(100, 50, 9);
          checks++;
          if (ready[3] !== 1'b1) begin errors++; $display("FAIL fd_ready3 got %b want 1", ready[3]); end
        end
        20: fdone[3] = 1'b1;
        30: fdone[2:0] = 3'b111;
        40: fdone[3] = 1'b1;
        default: ;
      endcase
    end
    fdone = '0; valid = '0;
    checks++;
    if (swap_cyc_q.size() != 2) begin
      errors++; $display("FAIL fd_swap_count got %0d want 2", swap_cyc_q.size());
    end else begin
      checks++;
      if (swap_cyc_q[0] != base + 22) begin
        errors++; $display("FAIL fd_swap_time got cycle %0d want %0d", swap_cyc_q[0] - base, 22);
      end
      checks++;
      if (wr_cyc_q.size() != 1 || wr_cyc_q[0] + 1 != swap_cyc_q[0]) begin
        errors++; $display("FAIL fd_swap_after_write got %0d writes swap %0d want 1 write one cycle before swap",
                           wr_cyc_q.size(), swap_cyc_q[0] - base);
      end
      checks++;
      if (swap_cyc_q[1] != base + 41) begin
        errors++; $display("FAIL fd_next_frame got cycle %0d want %0d", swap_cyc_q[1] - base, 41);
      end
    end
  endtask

  task automatic test_reset_midframe();
    int n0;
    apply_reset();
    push_exp(5, 2, 7);
    valid = 4'b0001;
    hc[0 +: HB] = 9'd5; vc[0 +: VB] = 8'd2; cc[0 +: CB] = 4'd7;
    @(negedge clk);
    valid = '0;
    wait_drain("mid_pre");
    valid = '1; fdone = 4'b0111;
    for (int i = 0; i < NC; i++) begin
      hc[i*HB +: HB] = HB'(i + 1); vc[i*VB +: VB] = 8'd1; cc[i*CB +: CB] = CB'(i + 10);
    end
    @(negedge clk);
    valid = '0; fdone = '0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (we !== 1'b0)   begin errors++; $display("FAIL mid_we got %b want 0", we); end
    checks++; if (addr !== '0)   begin errors++; $display("FAIL mid_addr got %0d want 0", addr); end
    checks++; if (data !== '0)   begin errors++; $display("FAIL mid_data got %0d want 0", data); end
    checks++; if (swap !== 1'b0) begin errors++; $display("FAIL mid_swap got %b want 0", swap); end
    checks++; if (ready !== '1)  begin errors++; $display("FAIL mid_ready got %b want 1111", ready); end
    repeat (10) @(negedge clk);
    checks++;
    if (swap_cyc_q.size() != 0) begin
      errors++; $display("FAIL mid_no_swap got %0d swaps want 0", swap_cyc_q.size());
    end
    n0 = swap_cyc_q.size();
    fdone = '1;
    @(negedge clk);
    fdone = '0;
    repeat (10) @(negedge clk);
    checks++;
    if (swap_cyc_q.size() - n0 != 1) begin
      errors++; $display("FAIL mid_swap_after got %0d swaps want 1", swap_cyc_q.size() - n0);
    end
  endtask

  initial begin
    rst = 1'b1; valid = '0; fdone = '0; hc = '0; vc = '0; cc = '0;
    repeat (2) @(negedge clk);
    test_reset();
    test_single_core();
    test_round_robin();
    test_out_of_range();
    test_frame_done();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
